load_store_unit: RTL and testbench



---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request, response and byte-memory signals of the load/store unit.
// The unit uses the slave modport; the core/memory environment uses master.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [11:0] req_offset;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_offset, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_offset, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer issuing one byte-wide memory access per cycle.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with rsp_err.
module load_store_unit (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] ea_q, ea_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic        sign_q, sign_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] req_ea;
    logic        req_legal;
    logic        req_misalign;
    logic [31:0] load_ext;

    assign req_ea = bus.req_addr + {{20{bus.req_offset[11]}}, bus.req_offset};

    always_comb begin
        req_legal = (bus.req_funct3[1:0] != 2'd3) &&
                    (bus.req_write ? !bus.req_funct3[2] : !(bus.req_funct3[2] && bus.req_funct3[1]));
`ifdef LSU_MISALIGN_TRAP_EN
        req_misalign = ((bus.req_funct3[1:0] == 2'd1) && req_ea[0]) ||
                       ((bus.req_funct3[1:0] == 2'd2) && (req_ea[1:0] != 2'd0));
`else
        req_misalign = 1'b0;
`endif
    end

    always_comb begin
        unique case (last_q)
            2'd0:    load_ext = {{24{sign_q & rdata_q[7]}}, rdata_q[7:0]};
            2'd1:    load_ext = {{16{sign_q & rdata_q[15]}}, rdata_q[15:0]};
            default: load_ext = rdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ea_q    <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sign_q  <= sign_d;
            write_q <= write_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ea_d          = ea_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        sign_d        = sign_q;
        write_d       = write_q;
        err_d         = err_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    ea_d    = req_ea;
                    cnt_d   = 2'd0;
                    // Size codes 0/1/2 map to last byte index 0/1/3.
                    last_d  = (bus.req_funct3[1:0] == 2'd2) ? 2'd3 : bus.req_funct3[1:0];
                    sign_d  = !bus.req_funct3[2];
                    write_d = bus.req_write;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = !req_legal || req_misalign;
                    state_d = err_d ? StResp : StAccess;
                end
            end
            StAccess: begin
                bus.mem_addr = ea_q + {30'd0, cnt_q};
                if (write_q) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
                end else begin
                    bus.mem_re = 1'b1;
                    rdata_d[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
                end
                if (cnt_q == last_q) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StResp: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_rdata = (err_q || write_q) ? 32'd0 : load_ext;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are forced quiet while reset is held so no strobe escapes the reset edge.
        if (rst) begin
            bus.req_ready = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.rsp_rdata = '0;
            bus.rsp_err   = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_re    = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_wdata = '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 1 KiB byte memory model.
module tb_load_store_unit;

    logic clk;
    logic rst;
    load_store_unit_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    logic       poke_en;
    logic [9:0] poke_addr;
    logic [7:0] poke_data;

    assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end

    int          checks;
    int          errors;
    int          re_n;
    int          we_n;
    int          both_n;
    int          rsp_cyc;
    int          rsp_n;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        ready_after;
    logic [31:0] addrs [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issue one request at a negedge and observe up to 10 cycles after acceptance.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [11:0] off, input logic [31:0] wd);
        int n;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_offset = off;
        bus.req_wdata  = wd;
        check("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hDEAD_0000;
        bus.req_wdata  = 32'h0;
        re_n = 0; we_n = 0; both_n = 0; rsp_cyc = 0; n = 0;
        rdata_o = 32'hx; err_o = 1'bx;
        for (int c = 1; c <= 10 && rsp_cyc == 0; c++) begin
            if (bus.mem_re && bus.mem_we) both_n++;
            if (bus.mem_re || bus.mem_we) begin
                addrs[n[2:0]] = bus.mem_addr;
                n++;
            end
            if (bus.mem_re) re_n++;
            if (bus.mem_we) we_n++;
            if (bus.rsp_valid) begin
                rsp_cyc = c;
                rdata_o = bus.rsp_rdata;
                err_o   = bus.rsp_err;
            end
            @(negedge clk);
        end
        ready_after = bus.req_ready;
    endtask

    initial begin
        checks = 0; errors = 0; rsp_n = 0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_offset = '0; bus.req_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_mem_re", {31'd0, bus.mem_re}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

        // lw little-endian assembly
        poke(10'h010, 8'h11); poke(10'h011, 8'h22); poke(10'h012, 8'h33); poke(10'h013, 8'h44);
        run_req(1'b0, 3'd2, 32'h10, 12'h000, 32'h0);
        check("lw_rsp_cycle", rsp_cyc, 32'd5);
        check("lw_rdata", rdata_o, 32'h4433_2211);
        check("lw_err", {31'd0, err_o}, 32'd0);
        check("lw_re_count", re_n, 32'd4);
        check("lw_we_count", we_n, 32'd0);
        check("lw_addr0", addrs[0], 32'h10);
        check("lw_addr3", addrs[3], 32'h13);
        check("lw_ready_after", {31'd0, ready_after}, 32'd1);

        // Byte and halfword extension
        poke(10'h040, 8'h80);
        run_req(1'b0, 3'd0, 32'h40, 12'h000, 32'h0);
        check("lb_rdata", rdata_o, 32'hFFFF_FF80);
        check("lb_rsp_cycle", rsp_cyc, 32'd2);
        run_req(1'b0, 3'd4, 32'h40, 12'h000, 32'h0);
        check("lbu_rdata", rdata_o, 32'h0000_0080);
        poke(10'h040, 8'h01); poke(10'h041, 8'h80);
        run_req(1'b0, 3'd1, 32'h40, 12'h000, 32'h0);
        check("lh_rdata", rdata_o, 32'hFFFF_8001);
        check("lh_rsp_cycle", rsp_cyc, 32'd3);
        run_req(1'b0, 3'd5, 32'h40, 12'h000, 32'h0);
        check("lhu_rdata", rdata_o, 32'h0000_8001);

        // sw with negative offset, then read back
        run_req(1'b1, 3'd2, 32'h100, 12'hFFC, 32'hDEAD_BEEF);
        check("sw_rsp_cycle", rsp_cyc, 32'd5);
        check("sw_rdata", rdata_o, 32'd0);
        check("sw_we_count", we_n, 32'd4);
        check("sw_re_count", re_n, 32'd0);
        check("sw_addr0", addrs[0], 32'hFC);
        check("sw_addr3", addrs[3], 32'hFF);
        check("sw_mem_fc", {24'd0, mem[10'h0FC]}, 32'hEF);
        check("sw_mem_fd", {24'd0, mem[10'h0FD]}, 32'hBE);
        check("sw_mem_fe", {24'd0, mem[10'h0FE]}, 32'hAD);
        check("sw_mem_ff", {24'd0, mem[10'h0FF]}, 32'hDE);
        run_req(1'b0, 3'd2, 32'hFC, 12'h000, 32'h0);
        check("sw_readback", rdata_o, 32'hDEAD_BEEF);

        // Misaligned halfword store
        poke(10'h021, 8'h00); poke(10'h022, 8'h00);
        run_req(1'b1, 3'd1, 32'h21, 12'h000, 32'h0000_ABCD);
`ifdef LSU_MISALIGN_TRAP_EN
        check("sh_mis_err", {31'd0, err_o}, 32'd1);
        check("sh_mis_rsp_cycle", rsp_cyc, 32'd1);
        check("sh_mis_we_count", we_n, 32'd0);
        check("sh_mis_mem21", {24'd0, mem[10'h021]}, 32'h00);
`else
        check("sh_mis_err", {31'd0, err_o}, 32'd0);
        check("sh_mis_rsp_cycle", rsp_cyc, 32'd3);
        check("sh_mis_mem21", {24'd0, mem[10'h021]}, 32'hCD);
        check("sh_mis_mem22", {24'd0, mem[10'h022]}, 32'hAB);

        // Misaligned word wrapping past the top of the address space
        poke(10'h3FE, 8'h01); poke(10'h3FF, 8'h02); poke(10'h000, 8'h03); poke(10'h001, 8'h04);
        run_req(1'b0, 3'd2, 32'hFFFF_FFFE, 12'h000, 32'h0);
        check("wrap_rdata", rdata_o, 32'h0403_0201);
        check("wrap_addr2", addrs[2], 32'h0);
`endif

        // Illegal funct3
        run_req(1'b0, 3'd3, 32'h10, 12'h000, 32'h0);
        check("ld_f3_3_err", {31'd0, err_o}, 32'd1);
        check("ld_f3_3_rsp_cycle", rsp_cyc, 32'd1);
        check("ld_f3_3_strobes", re_n + we_n, 32'd0);
        check("ld_f3_3_rdata", rdata_o, 32'd0);
        run_req(1'b1, 3'd4, 32'h10, 12'h000, 32'h1234_5678);
        check("st_f3_4_err", {31'd0, err_o}, 32'd1);
        check("st_f3_4_rsp_cycle", rsp_cyc, 32'd1);
        check("st_f3_4_strobes", re_n + we_n, 32'd0);
        check("st_f3_4_mem10", {24'd0, mem[10'h010]}, 32'h11);

        // Reset in the middle of a word store
        poke(10'h200, 8'hAA); poke(10'h201, 8'hAA); poke(10'h202, 8'hAA); poke(10'h203, 8'hAA);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h200;
        bus.req_offset = 12'h000;
        bus.req_wdata  = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rmid_we_byte0", {31'd0, bus.mem_we}, 32'd1);
        check("rmid_addr_byte0", bus.mem_addr, 32'h200);
        @(negedge clk);
        check("rmid_addr_byte1", bus.mem_addr, 32'h201);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rmid_we_in_rst", {31'd0, bus.mem_we}, 32'd0);
        check("rmid_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmid_ready_after", {31'd0, bus.req_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            if (bus.rsp_valid || bus.mem_we) rsp_n++;
            @(negedge clk);
        end
        check("rmid_no_activity", rsp_n, 32'd0);
        check("rmid_mem200", {24'd0, mem[10'h200]}, 32'h44);
        check("rmid_mem201", {24'd0, mem[10'h201]}, 32'h33);
        check("rmid_mem202", {24'd0, mem[10'h202]}, 32'hAA);
        check("rmid_mem203", {24'd0, mem[10'h203]}, 32'hAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
